// File: rtl/output_port_arbiter.sv
// -----------------------------------------------------------------------------
// output_port_arbiter
//   Round-robin arbiter and output register placed after the output port
//   cluster. It pops one packet per cycle from the granted port FIFO
//   (first-word-fall-through) and holds it in an output register. That
//   register drives the leaf-to-BFT path with a valid/ready handshake.
//
// Ports
//   i_clk           interface/BFT clock
//   i_reset         asynchronous active-high reset
//   i_internal_out  head packet of every port FIFO, port i at slice i
//   i_empty         per-port FIFO empty flags
//   o_rd_en_sel     one-hot pop strobe to the port FIFOs (combinational)
//   i_stall         cluster stall; blocks new grants only
//   o_out_packet    registered packet toward the BFT
//   o_out_valid     o_out_packet holds a packet
//   i_out_ready     downstream accepts o_out_packet this cycle
//   o_grant_idx     port index of the packet in o_out_packet
//   o_sent_cnt      packets accepted downstream, wraps modulo 2^32
//
// FSM states
//   state   | meaning
//   S_EMPTY | output register holds no packet, o_out_valid = 0
//   S_FULL  | output register holds a packet,  o_out_valid = 1
// -----------------------------------------------------------------------------
module output_port_arbiter #(
  parameter  int PACKET_BITS   = 97,
  parameter  int NUM_OUT_PORTS = 7,
  localparam int GRANT_BITS    = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic [PACKET_BITS*NUM_OUT_PORTS-1:0] i_internal_out,
  input  logic [NUM_OUT_PORTS-1:0]             i_empty,
  output logic [NUM_OUT_PORTS-1:0]             o_rd_en_sel,
  input  logic                                 i_stall,
  output logic [PACKET_BITS-1:0]               o_out_packet,
  output logic                                 o_out_valid,
  input  logic                                 i_out_ready,
  output logic [GRANT_BITS-1:0]                o_grant_idx,
  output logic [31:0]                          o_sent_cnt
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t                   r_state;
  logic [GRANT_BITS-1:0]    r_last_grant;
  logic [GRANT_BITS-1:0]    r_grant_idx;
  logic [PACKET_BITS-1:0]   r_out_packet;
  logic [31:0]              r_sent_cnt;

  logic                     w_found;
  int                       w_idx;
  logic [GRANT_BITS-1:0]    w_grant;
  logic                     w_load;
  logic [NUM_OUT_PORTS-1:0] w_rd_en;
  logic [PACKET_BITS-1:0]   w_head;

  // Search upward from last_grant+1, wrapping at NUM_OUT_PORTS. The sum
  // stays below 2*NUM_OUT_PORTS, so one conditional subtraction is the modulo.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      w_idx = int'(r_last_grant) + 1 + k;
      if (w_idx >= NUM_OUT_PORTS) w_idx = w_idx - NUM_OUT_PORTS;
      if (!w_found && !i_empty[w_idx[GRANT_BITS-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_idx[GRANT_BITS-1:0];
      end
    end
  end

  // w_found already implies at least one port is non-empty.
  assign w_load = ((r_state == S_EMPTY) || i_out_ready) && !i_stall && w_found;

  // Gating with i_reset makes the pop strobe drop as soon as reset asserts,
  // even though state is already EMPTY and ports may be non-empty.
  always_comb begin
    w_rd_en = '0;
    if (w_load && !i_reset) w_rd_en[w_grant] = 1'b1;
  end

  assign w_head = i_internal_out[int'(w_grant)*PACKET_BITS +: PACKET_BITS];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_EMPTY;
      r_out_packet <= '0;
      r_grant_idx  <= '0;
      r_last_grant <= GRANT_BITS'(NUM_OUT_PORTS - 1);
      r_sent_cnt   <= '0;
    end else begin
      if ((r_state == S_FULL) && i_out_ready) r_sent_cnt <= r_sent_cnt + 32'd1;

      if (w_load) begin
        r_state      <= S_FULL;
        r_out_packet <= w_head;
        r_grant_idx  <= w_grant;
        r_last_grant <= w_grant;
      end else if ((r_state == S_FULL) && i_out_ready) begin
        r_state <= S_EMPTY;
      end
    end
  end

  assign o_rd_en_sel  = w_rd_en;
  assign o_out_packet = r_out_packet;
  assign o_out_valid  = (r_state == S_FULL);
  assign o_grant_idx  = r_grant_idx;
  assign o_sent_cnt   = r_sent_cnt;

endmodule

// File: tb/tb_output_port_arbiter.sv
module tb_output_port_arbiter;
  localparam int P = 97;
  localparam int N = 7;

  typedef logic [P-1:0] pkt_t;

  logic           clk;
  logic           i_reset;
  logic [P*N-1:0] i_internal_out;
  logic [N-1:0]   i_empty;
  logic [N-1:0]   o_rd_en_sel;
  logic           i_stall;
  logic [P-1:0]   o_out_packet;
  logic           o_out_valid;
  logic           i_out_ready;
  logic [2:0]     o_grant_idx;
  logic [31:0]    o_sent_cnt;

  output_port_arbiter #(.PACKET_BITS(P), .NUM_OUT_PORTS(N)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_internal_out(i_internal_out),
    .i_empty(i_empty), .o_rd_en_sel(o_rd_en_sel), .i_stall(i_stall),
    .o_out_packet(o_out_packet), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_grant_idx(o_grant_idx), .o_sent_cnt(o_sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: port FIFOs as queues, output register as plain variables.
  pkt_t        q [N][$];
  logic        m_valid;
  pkt_t        m_pkt;
  int          m_gidx;
  int          m_last;
  logic [31:0] m_sent;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic pkt_t rand_pkt();
    return pkt_t'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic refresh();
    for (int p = 0; p < N; p++) begin
      i_empty[p] = (q[p].size() == 0);
      i_internal_out[p*P +: P] = (q[p].size() != 0) ? q[p][0] : '0;
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_pkt = '0; m_gidx = 0; m_last = N - 1; m_sent = '0;
  endtask

  // Port granted this cycle by the round-robin rule, or -1 when nothing loads.
  function automatic int exp_grant();
    if (!((!m_valid || i_out_ready) && !i_stall)) return -1;
    for (int d = 1; d <= N; d++) begin
      int p;
      p = (m_last + d) % N;
      if (q[p].size() != 0) return p;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_rd();
    int g;
    g = exp_grant();
    return (g >= 0) ? N'(1 << g) : '0;
  endfunction

  task automatic tick();
    int g;
    g = exp_grant();
    if (m_valid && i_out_ready) m_sent = m_sent + 1;
    if (g >= 0) begin
      m_pkt = q[g].pop_front(); m_gidx = g; m_last = g; m_valid = 1'b1;
    end else if (m_valid && i_out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    refresh();
  endtask

  task automatic drain();
    for (int p = 0; p < N; p++) q[p].delete();
    refresh();
    i_stall = 1'b0; i_out_ready = 1'b1;
    for (int i = 0; i < 4 && m_valid; i++) begin
      #1; tick();
    end
  endtask

  task automatic test_reset();
    i_out_ready = 1'b1; i_stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++;
      if (o_rd_en_sel !== '0) begin
        n_fail++; $display("FAIL reset_rd_en cyc %0d: got %b want 0", i, o_rd_en_sel);
      end
      tick();
      n_checks++;
      if (o_out_valid !== 1'b0 || o_sent_cnt !== 32'd0 || o_out_packet !== '0 || o_grant_idx !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_state cyc %0d: valid=%b sent=%0d gidx=%0d pkt=%h, want 0/0/0/0",
                 i, o_out_valid, o_sent_cnt, o_grant_idx, o_out_packet);
      end
    end
  endtask

  task automatic test_round_robin();
    for (int p = 0; p < N; p++) begin
      q[p].push_back(rand_pkt()); q[p].push_back(rand_pkt());
    end
    refresh();
    i_out_ready = 1'b1; i_stall = 1'b0;
    for (int i = 0; i < 2*N; i++) begin
      #1;
      n_checks++;
      if (o_rd_en_sel !== N'(1 << (i % N))) begin
        n_fail++; $display("FAIL rr_rd_en cyc %0d: got %b want port %0d", i, o_rd_en_sel, i % N);
      end
      tick();
      n_checks++;
      if (o_out_valid !== m_valid || o_out_packet !== m_pkt || o_grant_idx !== 3'(m_gidx)) begin
        n_fail++;
        $display("FAIL rr_out cyc %0d: valid=%b gidx=%0d pkt=%h want %b/%0d/%h",
                 i, o_out_valid, o_grant_idx, o_out_packet, m_valid, m_gidx, m_pkt);
      end
    end
    n_checks++;
    if (o_sent_cnt !== 32'd13 || o_out_valid !== 1'b1 || o_grant_idx !== 3'd6) begin
      n_fail++;
      $display("FAIL rr_final: sent=%0d valid=%b gidx=%0d want 13/1/6", o_sent_cnt, o_out_valid, o_grant_idx);
    end
  endtask

  task automatic test_two_ports();
    int seq [6] = '{2, 5, 2, 5, 2, 5};
    drain();
    q[5].push_back(rand_pkt());
    refresh();
    #1; tick();
    n_checks++;
    if (o_grant_idx !== 3'd5 || o_out_valid !== 1'b1) begin
      n_fail++; $display("FAIL two_setup: gidx=%0d valid=%b want 5/1", o_grant_idx, o_out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      q[2].push_back(rand_pkt()); q[5].push_back(rand_pkt());
    end
    refresh();
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if (o_rd_en_sel !== N'(1 << seq[i])) begin
        n_fail++; $display("FAIL two_rd_en step %0d: got %b want port %0d", i, o_rd_en_sel, seq[i]);
      end
      tick();
      n_checks++;
      if (o_grant_idx !== 3'(seq[i]) || o_out_packet !== m_pkt || o_sent_cnt !== m_sent) begin
        n_fail++;
        $display("FAIL two_out step %0d: gidx=%0d pkt=%h sent=%0d want %0d/%h/%0d",
                 i, o_grant_idx, o_out_packet, o_sent_cnt, seq[i], m_pkt, m_sent);
      end
    end
  endtask

  task automatic test_backpressure();
    pkt_t        first;
    pkt_t        second;
    logic [31:0] s0;
    first  = pkt_t'(97'h1_2345_6789_ABCD);
    second = rand_pkt();
    drain();
    q[3].push_back(first); q[3].push_back(second);
    refresh();
    #1;
    n_checks++;
    if (o_rd_en_sel !== 7'b0001000) begin
      n_fail++; $display("FAIL bp_load_rd_en: got %b want 0001000", o_rd_en_sel);
    end
    tick();
    i_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (o_rd_en_sel !== '0) begin
        n_fail++; $display("FAIL bp_hold_rd_en cyc %0d: got %b want 0", i, o_rd_en_sel);
      end
      tick();
      n_checks++;
      if (o_out_valid !== 1'b1 || o_out_packet !== first || o_grant_idx !== 3'd3) begin
        n_fail++;
        $display("FAIL bp_hold cyc %0d: valid=%b gidx=%0d pkt=%h want 1/3/%h",
                 i, o_out_valid, o_grant_idx, o_out_packet, first);
      end
    end
    s0 = m_sent;
    i_out_ready = 1'b1;
    #1;
    n_checks++;
    if (o_rd_en_sel !== 7'b0001000) begin
      n_fail++; $display("FAIL bp_release_rd_en: got %b want 0001000", o_rd_en_sel);
    end
    tick();
    n_checks++;
    if (o_sent_cnt !== s0 + 32'd1 || o_out_packet !== second || o_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: sent=%0d pkt=%h valid=%b want %0d/%h/1",
               o_sent_cnt, o_out_packet, o_out_valid, s0 + 32'd1, second);
    end
  endtask

  task automatic test_stall();
    logic [31:0] s0;
    drain();
    for (int i = 0; i < 2; i++) begin
      q[1].push_back(rand_pkt()); q[4].push_back(rand_pkt());
    end
    refresh();
    i_stall = 1'b1; i_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (o_rd_en_sel !== '0) begin
        n_fail++; $display("FAIL stall_empty_rd_en cyc %0d: got %b want 0", i, o_rd_en_sel);
      end
      tick();
      n_checks++;
      if (o_out_valid !== 1'b0) begin
        n_fail++; $display("FAIL stall_empty_valid cyc %0d: got %b want 0", i, o_out_valid);
      end
    end
    i_stall = 1'b0; i_out_ready = 1'b0;
    #1; tick();
    s0 = m_sent;
    i_stall = 1'b1; i_out_ready = 1'b1;
    #1;
    n_checks++;
    if (o_rd_en_sel !== '0) begin
      n_fail++; $display("FAIL stall_full_rd_en: got %b want 0", o_rd_en_sel);
    end
    tick();
    n_checks++;
    if (o_out_valid !== 1'b0 || o_sent_cnt !== s0 + 32'd1) begin
      n_fail++;
      $display("FAIL stall_full_deliver: valid=%b sent=%0d want 0/%0d", o_out_valid, o_sent_cnt, s0 + 32'd1);
    end
    i_stall = 1'b0;
    #1;
    n_checks++;
    if (o_rd_en_sel === '0 || o_rd_en_sel !== exp_rd()) begin
      n_fail++; $display("FAIL stall_resume_rd_en: got %b want %b", o_rd_en_sel, exp_rd());
    end
    tick();
  endtask

  task automatic test_async_reset();
    for (int p = 0; p < N; p++)
      for (int i = 0; i < 3; i++) q[p].push_back(rand_pkt());
    refresh();
    i_stall = 1'b0; i_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; tick();
    end
    #2;
    i_reset = 1'b1;
    #1;
    n_checks++;
    if (o_out_valid !== 1'b0 || o_rd_en_sel !== '0) begin
      n_fail++; $display("FAIL async_reset: valid=%b rd_en=%b want 0/0", o_out_valid, o_rd_en_sel);
    end
    model_reset();
    #3;
    i_reset = 1'b0;
    #1;
    n_checks++;
    if (o_rd_en_sel !== 7'b0000001) begin
      n_fail++; $display("FAIL post_reset_grant: got %b want 0000001", o_rd_en_sel);
    end
    tick();
    n_checks++;
    if (o_grant_idx !== 3'd0 || o_out_packet !== m_pkt || o_sent_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL post_reset_out: gidx=%0d pkt=%h sent=%0d want 0/%h/0", o_grant_idx, o_out_packet, o_sent_cnt, m_pkt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < N; p++)
        if (q[p].size() < 4 && $urandom_range(0, 9) < 3) q[p].push_back(rand_pkt());
      refresh();
      i_out_ready = ($urandom_range(0, 3) != 0);
      i_stall     = ($urandom_range(0, 7) == 0);
      #1;
      n_checks++;
      if (o_rd_en_sel !== exp_rd()) begin
        n_fail++; $display("FAIL rand_rd_en cyc %0d: got %b want %b", i, o_rd_en_sel, exp_rd());
      end
      tick();
      n_checks++;
      if (o_out_valid !== m_valid || o_out_packet !== m_pkt || o_grant_idx !== 3'(m_gidx) || o_sent_cnt !== m_sent) begin
        n_fail++;
        $display("FAIL rand_out cyc %0d: valid=%b gidx=%0d sent=%0d pkt=%h want %b/%0d/%0d/%h",
                 i, o_out_valid, o_grant_idx, o_sent_cnt, o_out_packet, m_valid, m_gidx, m_sent, m_pkt);
      end
    end
  endtask

  initial begin
    i_reset = 1'b1; i_stall = 1'b0; i_out_ready = 1'b0;
    for (int p = 0; p < N; p++) q[p].delete();
    refresh();
    model_reset();
    #12;
    i_reset = 1'b0;
    test_reset();
    test_round_robin();
    test_two_ports();
    test_backpressure();
    test_stall();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/output_port_arbiter.md
# output_port_arbiter

Round-robin arbiter and output register that sits directly downstream of the output port cluster in the leaf interface. It watches the per-port `empty` flags, pops one packet per cycle from the selected port FIFO through a one-hot `rd_en_sel`, and holds the packet in an output register. That register drives the leaf-to-BFT packet path with a valid/ready handshake. Fairness is strict round-robin over all non-empty ports, and the cluster stall condition freezes new grants.

## Interface
- `PACKET_BITS`, default 97: width of one packet on `internal_out` and `out_packet`.
- `NUM_OUT_PORTS`, default 7: number of output ports arbitrated; legal range 1–16.
- `GRANT_BITS`, localparam, clog2(NUM_OUT_PORTS), minimum 1: width of `grant_idx`.

- `clk` in 1: interface/BFT clock; all logic in this domain.
- `reset` in 1: asynchronous, active-high reset.
- `internal_out` in PACKET_BITS*NUM_OUT_PORTS: head packet of each port FIFO. Port i is at `[PACKET_BITS*(i+1)-1:PACKET_BITS*i]`.
- `empty` in NUM_OUT_PORTS: per-port FIFO empty flag. Head data is valid whenever the flag is low (first-word-fall-through).
- `rd_en_sel` out NUM_OUT_PORTS: one-hot pop strobe to the port FIFOs.
- `stall` in 1: cluster stall condition. While high, no new grant is issued.
- `out_packet` out PACKET_BITS: registered packet toward the BFT.
- `out_valid` out 1: `out_packet` holds a packet.
- `out_ready` in 1: downstream accepts `out_packet` this cycle.
- `grant_idx` out GRANT_BITS: index of the port whose packet is in `out_packet`.
- `sent_cnt` out 32: count of packets accepted downstream; wraps modulo 2^32.

## Operation
- Two-state FSM.
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- Load condition: `load` = (state==EMPTY || `out_ready`) && !`stall` && |~`empty`.
- Grant selection: the first non-empty port searching upward from `last_grant`+1 modulo NUM_OUT_PORTS, wrapping from NUM_OUT_PORTS-1 to 0. `last_grant` is a register.
- On `load`:
  - `rd_en_sel` has exactly one bit set (the granted port), combinationally in the same cycle.
  - Next edge: `out_packet` ← granted head, `grant_idx` and `last_grant` ← granted index, state → FULL.
- Otherwise `rd_en_sel`=0.
- Never assert `rd_en_sel[i]` while `empty[i]`=1, and never assert more than one bit.
- FULL && `out_ready` && !`load`: state → EMPTY. `out_packet` and `grant_idx` keep their last values.
- FULL && `out_ready` && `load`: back-to-back transfer. State stays FULL and the new packet replaces the old one.
- FULL && !`out_ready`: `out_packet`, `out_valid` and `grant_idx` are held stable. No pop occurs, regardless of `stall`.
- `stall` blocks only new grants. A packet already held is still delivered when `out_ready` rises.
- `sent_cnt` increments by 1 on every cycle where `out_valid` && `out_ready`.
- NUM_OUT_PORTS=1: the grant is always port 0 and `grant_idx`=0.
- Reset values:
  - state=EMPTY, `out_valid`=0, `out_packet`=0, `grant_idx`=0, `sent_cnt`=0, `rd_en_sel`=0.
  - `last_grant`=NUM_OUT_PORTS-1, so the first grant after reset searches from port 0.
- Reset mid-operation discards any held packet. A packet already popped from a FIFO is lost, and this is accepted behaviour.

## Timing
- Latency: a head becoming non-empty at edge N is granted in cycle N. `out_valid` rises after edge N+1, provided state is EMPTY and `stall` is low.
- Throughput: one packet per cycle while `out_ready` stays high and any port is non-empty.
- `rd_en_sel` is combinational from registered state, `empty`, `stall` and `out_ready`. There is no combinational path from `internal_out`.
- Handshake: a transfer occurs on a rising edge with `out_valid` && `out_ready`. `out_packet` must not change while `out_valid` && !`out_ready`.
- Fairness: with all ports continuously non-empty and `out_ready`=1, the grant sequence is 0,1,…,N-1,0,… with no port skipped.

## Test plan
- Reset, then `empty`=7'b1111111 for 10 cycles:
  - `rd_en_sel`=0, `out_valid`=0, `sent_cnt`=0 throughout.
- All 7 ports non-empty, `out_ready`=1, 14 cycles:
  - Grants 0..6,0..6 in order, one `rd_en_sel` bit per cycle.
  - `sent_cnt`=13 after the last handshake edge; the 14th packet is still in `out_packet`.
- Only ports 2 and 5 non-empty, `last_grant`=5:
  - Next grant is 2, then 5, then 2, wrapping correctly.
- Backpressure:
  - Load a packet 0x1_2345_6789_ABCD from port 3, then `out_ready`=0 for 5 cycles. `out_packet` stays stable, `rd_en_sel`=0, `out_valid`=1.
  - `out_ready`=1 for one cycle: `sent_cnt` +1, and the next packet loads on the same edge.
- `stall`=1 with ports non-empty and state EMPTY:
  - No `rd_en_sel`.
  - If state is FULL, the held packet still completes when `out_ready`=1. Grants resume the cycle after `stall`=0.
- Assert `reset` asynchronously mid-burst with state FULL:
  - `out_valid` and `rd_en_sel` drop immediately, without waiting for a clock edge.
  - After release, the first grant is port 0 (given port 0 is non-empty).
